// File: rtl/spi_pwm_engine.sv
// spi_pwm_engine
//   Consumes the SPI register block's parallel outputs. Every completed SPI
//   transaction (rising ncs) captures control/period/compare. A 32-bit
//   PWM / one-shot pulse generator runs from the active copy. Changes made
//   while running are applied at the next period boundary.
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   ncs     raw SPI chip select, asynchronous to clk
//   q_c     control byte: [4] enable, [5] one_shot, [6] invert, [7] restart
//   q_0     period word (period+1 cycles per period)
//   q_1     compare word (pwm high while cnt < compare)
//   pwm     generated waveform (registered)
//   busy    high while running
//   wrap    high in the last cycle of each period
//   cnt     current counter value
//   status  {busy, pending, oneshot_done, pwm, 4'h5}
module spi_pwm_engine #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        IDLE_LEVEL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ncs,
   input  logic [7:0]  q_c,
   input  logic [31:0] q_0,
   input  logic [31:0] q_1,
   output logic        pwm,
   output logic        busy,
   output logic        wrap,
   output logic [31:0] cnt,
   output logic [7:0]  status
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_n;

   // Stored control bits: [1] invert, [0] one_shot.
   logic [1:0]  act_ctrl, act_ctrl_n, pend_ctrl, pend_ctrl_n;
   logic [31:0] act_period, act_period_n, pend_period, pend_period_n;
   logic [31:0] act_compare, act_compare_n, pend_compare, pend_compare_n;
   logic [31:0] cnt_n;
   logic        pending, pending_n;
   logic        oneshot_done, oneshot_done_n;
   logic        pwm_n;
   logic        period_end;

   // Low control bits are meant for other consumers of the control byte.
   logic        ctrl_unused;
   assign ctrl_unused = ^q_c[3:0];

   // Chip-select synchroniser; idles high so reset never looks like a rise.
   logic [SYNC_STAGES-1:0] ncs_sync;
   logic                   ncs_prev;
   logic                   commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ncs_sync <= '1;
         ncs_prev <= 1'b1;
      end else begin
         ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], ncs};
         ncs_prev <= ncs_sync[SYNC_STAGES-1];
      end
   end

   assign commit     = ncs_sync[SYNC_STAGES-1] & ~ncs_prev;
   assign period_end = (state == S_RUN) && (cnt == act_period);

   // Counter/boundary behaviour is resolved first; a commit then overrides it,
   // which gives the newest transaction priority over a pending update.
   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      act_ctrl_n     = act_ctrl;
      act_period_n   = act_period;
      act_compare_n  = act_compare;
      pend_ctrl_n    = pend_ctrl;
      pend_period_n  = pend_period;
      pend_compare_n = pend_compare;
      pending_n      = pending;
      oneshot_done_n = oneshot_done;
      pwm_n          = (state == S_RUN) ? ((cnt < act_compare) ^ act_ctrl[1])
                                        : (IDLE_LEVEL ^ act_ctrl[1]);

      case (state)
         S_RUN: begin
            if (period_end) begin
               cnt_n = '0;
               if (act_ctrl[0]) begin
                  state_n        = S_DONE;
                  oneshot_done_n = 1'b1;
               end else if (pending) begin
                  act_ctrl_n    = pend_ctrl;
                  act_period_n  = pend_period;
                  act_compare_n = pend_compare;
                  pending_n     = 1'b0;
               end
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_IDLE, S_DONE: cnt_n = '0;
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase

      if (commit) begin
         pend_ctrl_n    = q_c[6:5];
         pend_period_n  = q_0;
         pend_compare_n = q_1;
         pending_n      = 1'b1;
         if (!q_c[4]) begin
            state_n       = S_IDLE;
            cnt_n         = '0;
            act_ctrl_n    = q_c[6:5];
            act_period_n  = q_0;
            act_compare_n = q_1;
            pending_n     = 1'b0;
         end else if (q_c[7] || (state != S_RUN)) begin
            state_n        = S_RUN;
            cnt_n          = '0;
            act_ctrl_n     = q_c[6:5];
            act_period_n   = q_0;
            act_compare_n  = q_1;
            pending_n      = 1'b0;
            oneshot_done_n = 1'b0;
         end else if (period_end && !act_ctrl[0]) begin
            act_ctrl_n    = q_c[6:5];
            act_period_n  = q_0;
            act_compare_n = q_1;
            pending_n     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         act_ctrl     <= '0;
         act_period   <= '0;
         act_compare  <= '0;
         pend_ctrl    <= '0;
         pend_period  <= '0;
         pend_compare <= '0;
         pending      <= 1'b0;
         oneshot_done <= 1'b0;
         pwm          <= IDLE_LEVEL;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         act_ctrl     <= act_ctrl_n;
         act_period   <= act_period_n;
         act_compare  <= act_compare_n;
         pend_ctrl    <= pend_ctrl_n;
         pend_period  <= pend_period_n;
         pend_compare <= pend_compare_n;
         pending      <= pending_n;
         oneshot_done <= oneshot_done_n;
         pwm          <= pwm_n;
      end
   end

   assign busy   = (state == S_RUN);
   assign wrap   = period_end;
   assign status = {busy, pending, oneshot_done, pwm, 4'h5};

endmodule

// File: tb/tb_spi_pwm_engine.sv
// Testbench for spi_pwm_engine: directed scenarios plus randomized
// transactions, all compared against a cycle-level reference model.
module tb_spi_pwm_engine;

   localparam int unsigned SYNC    = 2;
   localparam logic        IDLE_LV = 1'b0;
   localparam int          M_IDLE  = 0;
   localparam int          M_RUN   = 1;
   localparam int          M_DONE  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ncs;
   logic [7:0]  q_c;
   logic [31:0] q_0, q_1;
   logic        pwm, busy, wrap;
   logic [31:0] cnt;
   logic [7:0]  status;
   logic [42:0] outv;

   int checks;
   int fails;

   spi_pwm_engine #(.SYNC_STAGES(SYNC), .IDLE_LEVEL(IDLE_LV)) dut (
      .clk(clk), .rst(rst), .ncs(ncs), .q_c(q_c), .q_0(q_0), .q_1(q_1),
      .pwm(pwm), .busy(busy), .wrap(wrap), .cnt(cnt), .status(status)
   );

   always #5 clk = ~clk;

   assign outv = {busy, wrap, pwm, status, cnt};

   // ---------------- reference model ----------------
   int          m_state;
   logic [31:0] m_cnt, m_per, m_cmp, p_per, p_cmp;
   logic [7:0]  m_ctl, p_ctl;
   bit          m_pend, m_done, m_pwm;
   bit          hist [0:SYNC];   // hist[k] = ncs sampled k+1 edges ago

   initial begin : ref_model
      bit cm, at_end, npwm, one0;
      int st0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_state = M_IDLE; m_cnt = 0; m_per = 0; m_cmp = 0; m_ctl = 0;
            p_per = 0; p_cmp = 0; p_ctl = 0;
            m_pend = 0; m_done = 0; m_pwm = IDLE_LV;
            for (int k = 0; k <= SYNC; k++) hist[k] = 1'b1;
         end else begin
            // rise seen SYNC samples back becomes a commit now
            cm = hist[SYNC-1] && !hist[SYNC];
            for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ncs;
            st0    = m_state;
            one0   = m_ctl[5];
            at_end = (m_state == M_RUN) && (m_cnt == m_per);
            npwm   = (m_state == M_RUN) ? ((m_cnt < m_cmp) ^ m_ctl[6]) : (IDLE_LV ^ m_ctl[6]);
            if (m_state == M_RUN) begin
               if (!at_end) m_cnt = m_cnt + 1;
               else begin
                  m_cnt = 0;
                  if (one0) begin m_state = M_DONE; m_done = 1; end
                  else if (m_pend) begin
                     m_ctl = p_ctl; m_per = p_per; m_cmp = p_cmp; m_pend = 0;
                  end
               end
            end
            if (cm) begin
               p_ctl = q_c; p_per = q_0; p_cmp = q_1;
               if (!q_c[4]) begin
                  m_state = M_IDLE; m_cnt = 0; m_pend = 0;
                  m_ctl = q_c; m_per = q_0; m_cmp = q_1;
               end else if (q_c[7] || st0 != M_RUN) begin
                  m_state = M_RUN; m_cnt = 0; m_pend = 0; m_done = 0;
                  m_ctl = q_c; m_per = q_0; m_cmp = q_1;
               end else if (at_end && !one0) begin
                  m_ctl = q_c; m_per = q_0; m_cmp = q_1; m_pend = 0;
               end else begin
                  m_pend = 1;
               end
            end
            m_pwm = npwm;
         end
      end
   end

   function automatic logic [42:0] model_vec();
      logic run;
      run = (m_state == M_RUN);
      return {run, run && (m_cnt == m_per), m_pwm, run, m_pend, m_done, m_pwm, 4'h5, m_cnt};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      q_c = 8'h00; q_0 = 32'd0; q_1 = 32'd0; ncs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== {1'b0, 1'b0, IDLE_LV, 8'h05, 32'd0}) begin
            fails++; $display("FAIL reset_hold: got %h expected %h", outv, {1'b0, 1'b0, IDLE_LV, 8'h05, 32'd0});
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec() || busy !== 1'b0) begin
            fails++; $display("FAIL reset_release: got %h expected %h", outv, model_vec());
         end
      end
   endtask

   task automatic test_pwm_basic();
      int wraps, highs;
      wraps = 0; highs = 0;
      @(negedge clk);
      q_c = 8'h10; q_0 = 32'd9; q_1 = 32'd3; ncs = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL basic_model: got %h expected %h", outv, model_vec());
         end
         if (i == 3) begin
            checks++;
            if (busy !== 1'b0) begin fails++; $display("FAIL commit_early: busy=%b required 0", busy); end
         end
         if (i == 4) begin
            checks++;
            if (busy !== 1'b1) begin fails++; $display("FAIL commit_latency: busy=%b required 1", busy); end
         end
         if (i >= 5 && i < 35) begin wraps += int'(wrap); highs += int'(pwm); end
         if (i == 1) ncs = 1'b1;
      end
      checks++;
      if (wraps != 3 || highs != 9) begin
         fails++; $display("FAIL basic_counts: wraps=%0d highs=%0d required 3 and 9", wraps, highs);
      end
   endtask

   task automatic test_pending();
      int w1, w2, rs, highs;
      bit armed;
      bit ph [0:79];
      bit pn [0:79];
      w1 = -1; w2 = -1; rs = 1000; armed = 0; highs = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         ph[i] = pwm; pn[i] = status[6];
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL pending_model: got %h expected %h", outv, model_vec());
         end
         if (armed && i >= rs + 3 && w1 < 0) begin
            checks++;
            if (status[6] !== 1'b1) begin fails++; $display("FAIL pending_flag: status[6]=%b required 1", status[6]); end
            if (wrap) w1 = i;
         end else if (w1 >= 0 && w2 < 0 && wrap) begin
            w2 = i;
         end
         if (!armed && m_state == M_RUN && m_cnt == 32'd1) begin
            q_c = 8'h10; q_0 = 32'd4; q_1 = 32'd2; ncs = 1'b0; armed = 1; rs = i + 1;
         end
         if (i == rs) ncs = 1'b1;
      end
      checks++;
      if (w1 < 0 || w2 < 0 || w1 + 6 > 79) begin
         fails++; $display("FAIL pending_wrap: w1=%0d w2=%0d required both found", w1, w2);
      end else begin
         for (int k = w1 + 2; k <= w1 + 6; k++) highs += int'(ph[k]);
         if (w2 - w1 != 5 || highs != 2 || pn[w1 + 1] != 1'b0) begin
            fails++; $display("FAIL pending_period: len=%0d highs=%0d pend_after=%0d required 5 2 0",
                              w2 - w1, highs, pn[w1 + 1]);
         end
      end
   endtask

   task automatic test_one_shot();
      int d, highs, wraps;
      bit ph [0:63];
      bit wh [0:63];
      d = -1; highs = 0; wraps = 0;
      @(negedge clk);
      q_c = 8'h30; q_0 = 32'd7; q_1 = 32'd8; ncs = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         ph[i] = pwm; wh[i] = wrap;
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL oneshot_model: got %h expected %h", outv, model_vec());
         end
         if (d >= 0 && i > d && i <= d + 3) begin
            checks++;
            if (status !== 8'h25 || busy !== 1'b0 || cnt !== 32'd0) begin
               fails++; $display("FAIL oneshot_done: status=%h busy=%b cnt=%0d required 25 0 0", status, busy, cnt);
            end
         end
         if (d < 0 && i > 3 && !busy) d = i;
         if (i == 0) ncs = 1'b1;
      end
      checks++;
      if (d < 9) begin
         fails++; $display("FAIL oneshot_end: index=%0d required >= 9", d);
      end else begin
         for (int k = d - 7; k <= d; k++) highs += int'(ph[k]);
         for (int k = d - 8; k <= d; k++) wraps += int'(wh[k]);
         if (highs != 8 || ph[d - 8] != 1'b0 || wraps != 1) begin
            fails++; $display("FAIL oneshot_shape: highs=%0d lead=%0d wraps=%0d required 8 0 1",
                              highs, ph[d - 8], wraps);
         end
      end
   endtask

   task automatic test_invert();
      @(negedge clk);
      q_c = 8'h50; q_0 = 32'd3; q_1 = 32'd0; ncs = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL invert_model: got %h expected %h", outv, model_vec());
         end
         if (i >= 4) begin
            checks++;
            if (pwm !== 1'b1) begin fails++; $display("FAIL invert_level: pwm=%b required 1", pwm); end
         end
         if (i == 0) ncs = 1'b1;
      end
      q_c = 8'h40; q_0 = 32'd3; q_1 = 32'd0; ncs = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL stop_model: got %h expected %h", outv, model_vec());
         end
         if (i >= 3) begin
            checks++;
            if ({busy, cnt, pwm} !== {1'b0, 32'd0, 1'b1}) begin
               fails++; $display("FAIL stop_idle: busy=%b cnt=%0d pwm=%b required 0 0 1", busy, cnt, pwm);
            end
         end
         if (i == 0) ncs = 1'b1;
      end
   endtask

   task automatic test_restart();
      int rs, w;
      rs = 1000; w = -1;
      @(negedge clk);
      q_c = 8'h10; q_0 = 32'd9; q_1 = 32'd3; ncs = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL restart_model: got %h expected %h", outv, model_vec());
         end
         if (i == rs + 2) begin
            checks++;
            if (cnt !== 32'd6) begin fails++; $display("FAIL restart_before: cnt=%0d required 6", cnt); end
         end
         if (i == rs + 3) begin
            checks++;
            if (cnt !== 32'd0 || busy !== 1'b1) begin
               fails++; $display("FAIL restart_now: cnt=%0d busy=%b required 0 1", cnt, busy);
            end
         end
         if (i > rs + 3 && wrap && w < 0) w = i;
         if (i == 0) ncs = 1'b1;
         if (i > 3 && rs == 1000 && m_state == M_RUN && m_cnt == 32'd3) begin
            q_c = 8'h90; q_0 = 32'd5; q_1 = 32'd1; ncs = 1'b0; rs = i + 1;
         end
         if (i == rs) ncs = 1'b1;
      end
      checks++;
      if (w < 0 || w - (rs + 3) != 5) begin
         fails++; $display("FAIL restart_period: wrap_offset=%0d required 5", w - (rs + 3));
      end
   endtask

   task automatic test_reset_mid();
      bit found, prev_busy;
      int rises;
      found = 0; rises = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL midrst_model: got %h expected %h", outv, model_vec());
         end
         if (m_state == M_RUN && m_cnt == 32'd4) found = 1;
      end
      checks++;
      if (!found) begin fails++; $display("FAIL midrst_arm: cnt never reached 4"); end
      #2 rst = 1'b1;
      #1 checks++;
      if ({busy, cnt, status} !== {1'b0, 32'd0, 8'h05}) begin
         fails++; $display("FAIL midrst_async: busy=%b cnt=%0d status=%h required 0 0 05", busy, cnt, status);
      end
      #1 ncs = 1'b0;
      #3 ncs = 1'b1;
      #5 ncs = 1'b0;
      #6 ncs = 1'b1;
      #4 ncs = 1'b0;
      q_c = 8'h10; q_0 = 32'd9; q_1 = 32'd3;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (outv !== {1'b0, 1'b0, IDLE_LV, 8'h05, 32'd0} || outv !== model_vec()) begin
            fails++; $display("FAIL midrst_quiet: got %h expected %h", outv, model_vec());
         end
      end
      ncs = 1'b1;
      prev_busy = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         checks++;
         if (outv !== model_vec()) begin
            fails++; $display("FAIL midrst_model2: got %h expected %h", outv, model_vec());
         end
         if (j == 1) begin
            checks++;
            if (busy !== 1'b0) begin fails++; $display("FAIL midrst_early: busy=%b required 0", busy); end
         end
         if (j == 2) begin
            checks++;
            if (busy !== 1'b1) begin fails++; $display("FAIL midrst_commit: busy=%b required 1", busy); end
         end
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
      end
      checks++;
      if (rises != 1) begin fails++; $display("FAIL midrst_once: starts=%0d required 1", rises); end
   endtask

   task automatic test_random();
      int lo, hi;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         q_c = 8'($urandom);
         q_0 = $urandom_range(0, 12);
         q_1 = $urandom_range(0, 14);
         ncs = 1'b0;
         lo  = int'($urandom_range(1, 4));
         hi  = int'($urandom_range(4, 25));
         for (int i = 0; i < lo + hi; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== model_vec()) begin
               fails++; $display("FAIL random_t%0d_c%0d: got %h expected %h", t, i, outv, model_vec());
            end
            if (i == lo - 1) ncs = 1'b1;
         end
      end
   endtask

   initial begin
      checks = 0; fails = 0;
      rst = 1'b0; ncs = 1'b1; q_c = 8'h00; q_0 = 32'd0; q_1 = 32'd0;
      #1 rst = 1'b1;
      test_reset();
      test_pwm_basic();
      test_pending();
      test_one_shot();
      test_invert();
      test_restart();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
